// File: rtl/operand_entry.sv
// Operand-entry stage for the 4-bit comparator: debounced KEY[0]/KEY[1]
// stage and clear two operands; registered, glitch-free outputs.
module operand_entry #(
    parameter int DB_CYCLES = 500000,
    parameter int WIDTH     = 4
) (
    input  logic             MAX10_CLK1_50,
    input  logic             rst,
    input  logic [9:0]       SW,
    input  logic [1:0]       KEY,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             twos,
    output logic             ready,
    output logic             cmp_valid,
    output logic [1:0]       LEDR
);

    localparam int CW = $clog2(DB_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        A_LOADED = 2'b01,
        READY    = 2'b10,
        UNUSED   = 2'b11
    } state_t;

    logic          clk;
    logic [1:0]    key_s1_q, key_s2_q;
    logic [1:0]    db_q, db_d, db_prev_q;
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic [1:0]    press;
    logic [9:0]    sw_s1_q, sw_s2_q;
    logic          unused_sw;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic            twos_q, twos_d, cmp_q, cmp_d;

    assign clk       = MAX10_CLK1_50;
    assign unused_sw = ^sw_s2_q[7:WIDTH];

    // Synchronise raw KEY and SW; keys idle high (released)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_s1_q <= 2'b11;
            key_s2_q <= 2'b11;
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
        end else begin
            key_s1_q <= KEY;
            key_s2_q <= key_s1_q;
            sw_s1_q  <= SW;
            sw_s2_q  <= sw_s1_q;
        end
    end

    // Debounce: a differing level must persist DB_CYCLES clocks to be taken
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = cnt_q[i];
            db_d[i]  = db_q[i];
            if (key_s2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                db_d[i]  = key_s2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Debounce state and previous debounced level for edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= '0;
            end
            db_q      <= 2'b11;
            db_prev_q <= 2'b11;
        end else begin
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            db_q      <= db_d;
            db_prev_q <= db_q;
        end
    end

    // Press is the released-to-pressed edge of the debounced level
    assign press = db_prev_q & ~db_q;

    // Next state and operand captures; clear beats enter
    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        twos_d  = twos_q;
        if (press[1]) begin
            state_d = IDLE;
            op_a_d  = '0;
            op_b_d  = '0;
            twos_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (press[0]) begin
                        op_a_d  = sw_s2_q[WIDTH-1:0];
                        state_d = A_LOADED;
                    end
                end
                A_LOADED: begin
                    if (press[0]) begin
                        op_b_d  = sw_s2_q[WIDTH-1:0];
                        twos_d  = (sw_s2_q[9:8] == 2'b11);
                        state_d = READY;
                    end
                end
                READY: begin
                    if (press[0]) begin
                        op_a_d  = sw_s2_q[WIDTH-1:0];
                        state_d = A_LOADED;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        cmp_d = (state_d == READY) && (state_q != READY);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            twos_q  <= 1'b0;
            cmp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            twos_q  <= twos_d;
            cmp_q   <= cmp_d;
        end
    end

    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign twos      = twos_q;
    assign ready     = (state_q == READY);
    assign cmp_valid = cmp_q;
    assign LEDR      = state_q;

endmodule
